// File: rtl/ble_pkg.sv
// Shared types and buffer defaults for the BLE receive path.
// The firmware header generator and the top-level arbiter read the same constants.
package ble_pkg;

  localparam logic [31:0] BLE_BUF_BASE = 32'h0000_1C00;
  localparam int          BLE_BUF_SIZE = 1024;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    BIDLE,
    BWRITE
  } bus_state_t;

  // One-hot byte lane select for a byte address offset within a word.
  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    lane_sel = 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser plus a bit-timing FSM.
// It emits single-cycle valid / frame_err pulses and is shared with the PC link.
module uart_rx_core
  import ble_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             sample;

  // The line idles high, so the synchroniser also resets high to avoid a fake start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign sample = ((state == RX_START) && (cnt == HALF_LAST)) ||
                  (((state == RX_DATA) || (state == RX_STOP)) && (cnt == FULL_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_next = RX_START;
      RX_START: if (sample) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample && (bit_idx == 3'd7)) state_next = RX_STOP;
      RX_STOP:  if (sample) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    valid     = (state == RX_STOP) && sample && rx_sync;
    frame_err = (state == RX_STOP) && sample && !rx_sync;
  end

  // The bit timer restarts at every sample point, so each phase measures from the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if ((state == RX_IDLE) || sample) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state != RX_DATA) begin
        bit_idx <= '0;
      end else if (sample) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {rx_sync, shreg[7:1]};
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ble_rx_dma.sv
// BLE receive DMA: UART bytes are queued in a small FIFO and written as
// single-byte Wishbone writes into a circular window of the shared RAM.
module ble_rx_dma
  import ble_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] BUF_BASE     = BLE_BUF_BASE,
  parameter int          BUF_SIZE     = BLE_BUF_SIZE,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                        i_wb_clk,
  input  logic                        i_wb_rst,
  input  logic                        i_rx,
  output logic [31:0]                 o_wb_adr,
  output logic [31:0]                 o_wb_dat,
  output logic [3:0]                  o_wb_sel,
  output logic                        o_wb_we,
  output logic                        o_wb_cyc,
  input  logic                        i_wb_ack,
  output logic [$clog2(BUF_SIZE)-1:0] o_wr_ptr,
  output logic                        o_overflow,
  output logic                        o_frame_err,
  input  logic                        i_clr
);

  localparam int PTR_W = $clog2(BUF_SIZE);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_ferr;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;

  bus_state_t       bus_state;
  bus_state_t       bus_next;
  logic             load;
  logic [PTR_W-1:0] ptr;
  logic [31:0]      ptr_addr;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (i_wb_clk),
    .rst      (i_wb_rst),
    .rx       (i_rx),
    .rx_byte  (rx_byte),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted then.
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = rx_valid && (!fifo_full || pop);
  assign drop       = rx_valid && fifo_full && !pop;

  always_ff @(posedge i_wb_clk) begin
    if (push) begin
      fifo_mem[wr_idx] <= rx_byte;
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + IDX_W'(1);
      if (pop)  rd_idx <= rd_idx + IDX_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      bus_state <= BIDLE;
    end else begin
      bus_state <= bus_next;
    end
  end

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BIDLE:   if (!fifo_empty) bus_next = BWRITE;
      BWRITE:  if (i_wb_ack) bus_next = BIDLE;
      default: bus_next = BIDLE;
    endcase
  end

  // cyc/we come straight from the state register, so they carry no combinational input path.
  always_comb begin
    o_wb_cyc = (bus_state == BWRITE);
    o_wb_we  = (bus_state == BWRITE);
    load     = (bus_state == BIDLE) && !fifo_empty;
    pop      = (bus_state == BWRITE) && i_wb_ack;
  end

  assign ptr_addr = BUF_BASE + {{(32 - PTR_W){1'b0}}, ptr};

  // Address, data and lane are captured once on entry to BWRITE and held until ack.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_wb_adr <= '0;
      o_wb_sel <= '0;
      o_wb_dat <= '0;
    end else if (load) begin
      o_wb_adr <= {ptr_addr[31:2], 2'b00};
      o_wb_sel <= lane_sel(ptr_addr[1:0]);
      o_wb_dat <= {4{fifo_mem[rd_idx]}};
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      ptr <= '0;
    end else if (pop) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  assign o_wr_ptr = ptr;

  // A set event in the same cycle as the clear keeps the flag high.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_overflow  <= drop    | (o_overflow  & ~i_clr);
      o_frame_err <= rx_ferr | (o_frame_err & ~i_clr);
    end
  end

endmodule

// File: tb/tb_ble_rx_dma.sv
// Self-checking bench for ble_rx_dma: UART frames in, Wishbone writes checked
// against a byte-queue / pointer model of the circular buffer.
module tb_ble_rx_dma;

  localparam int          CPB   = 16;
  localparam logic [31:0] BASE  = 32'h0000_1C00;
  localparam int          BSIZE = 64;
  localparam int          DEPTH = 4;
  localparam int          PW    = $clog2(BSIZE);

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic          ack = 1'b0;
  logic          clr = 1'b0;
  logic [31:0]   wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic [PW-1:0] wr_ptr;
  logic          overflow;
  logic          frame_err;

  wr_t obs[$];
  int  ack_mode = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  mptr     = 0;

  always #5 clk = ~clk;

  ble_rx_dma #(
    .CLKS_PER_BIT(CPB),
    .BUF_BASE    (BASE),
    .BUF_SIZE    (BSIZE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_rx       (rx),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_ack   (ack),
    .o_wr_ptr   (wr_ptr),
    .o_overflow (overflow),
    .o_frame_err(frame_err),
    .i_clr      (clr)
  );

  // Bus slave: decides ack half a cycle ahead and logs each write it is about to accept.
  always @(negedge clk) begin
    logic take;
    take = 1'b0;
    if (rst) begin
      ack = 1'b0;
    end else begin
      case (ack_mode)
        1:       take = wb_cyc;
        2:       take = wb_cyc && ($urandom_range(0, 2) == 0);
        default: take = 1'b0;
      endcase
      if (take) obs.push_back({wb_adr, wb_sel, wb_dat});
      ack = take;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected write for byte b at buffer offset p, from the address arithmetic of the buffer window.
  function automatic wr_t exp_write(input logic [7:0] b, input int p);
    logic [31:0] a;
    a = BASE + 32'(p);
    exp_write.adr = a - (a % 4);
    exp_write.sel = 4'(1 << (a % 4));
    exp_write.dat = {4{b}};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs.delete();
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input string name);
    int budget = 400;
    while ((obs.size() < n) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (obs.size() < n) begin
      n_fail++;
      $display("[TB] FAIL %s_wait: writes seen %0d, required %0d", name, obs.size(), n);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks += 8;
    if (wb_cyc !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_cyc: got %b, required 0", wb_cyc); end
    if (wb_we !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_we: got %b, required 0", wb_we); end
    if (wb_sel !== 4'b0)    begin n_fail++; $display("[TB] FAIL reset_sel: got %h, required 0", wb_sel); end
    if (wb_adr !== 32'b0)   begin n_fail++; $display("[TB] FAIL reset_adr: got %h, required 0", wb_adr); end
    if (wb_dat !== 32'b0)   begin n_fail++; $display("[TB] FAIL reset_dat: got %h, required 0", wb_dat); end
    if (wr_ptr !== '0)      begin n_fail++; $display("[TB] FAIL reset_ptr: got %0d, required 0", wr_ptr); end
    if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_ovf: got %b, required 0", overflow); end
    if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ferr: got %b, required 0", frame_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_bytes();
    wr_t o;
    do_reset();
    ack_mode = 1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_writes(2, "two_bytes");
    n_checks += 3;
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    if (o !== {BASE, 4'b0001, 32'hA5A5A5A5})
      begin n_fail++; $display("[TB] FAIL two_bytes_w0: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    if (o !== {BASE, 4'b0010, 32'h3C3C3C3C})
      begin n_fail++; $display("[TB] FAIL two_bytes_w1: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
    if (wr_ptr !== PW'(2))
      begin n_fail++; $display("[TB] FAIL two_bytes_ptr: got %0d, required 2", wr_ptr); end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic       any_bad = 1'b0;
    do_reset();
    ack_mode = 2;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_byte(b, !bad);
      if (bad) any_bad = 1'b1;
      else     exp.push_back(b);
    end
    wait_writes(exp.size(), "random");
    foreach (exp[i]) begin
      wr_t e, o;
      e    = exp_write(exp[i], mptr);
      mptr = (mptr + 1) % BSIZE;
      o    = (obs.size() > 0) ? obs.pop_front() : '0;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL random_w%0d: got adr=%h sel=%b dat=%h, required adr=%h sel=%b dat=%h",
                 i, o.adr, o.sel, o.dat, e.adr, e.sel, e.dat);
      end
    end
    n_checks += 4;
    if (obs.size() != 0)        begin n_fail++; $display("[TB] FAIL random_extra: got %0d extra writes, required 0", obs.size()); end
    if (frame_err !== any_bad)  begin n_fail++; $display("[TB] FAIL random_ferr: got %b, required %b", frame_err, any_bad); end
    if (overflow !== 1'b0)      begin n_fail++; $display("[TB] FAIL random_ovf: got %b, required 0", overflow); end
    if (wr_ptr !== PW'(mptr))   begin n_fail++; $display("[TB] FAIL random_ptr: got %0d, required %0d", wr_ptr, mptr); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    wr_t        o;
    do_reset();
    ack_mode = 1;
    for (int i = 0; i < BSIZE - 1; i++) begin
      exp.push_back(8'($urandom));
      send_byte(exp[i], 1'b1);
    end
    wait_writes(BSIZE - 1, "wrap_fill");
    foreach (exp[i]) begin
      wr_t e;
      e    = exp_write(exp[i], mptr);
      mptr = (mptr + 1) % BSIZE;
      o    = (obs.size() > 0) ? obs.pop_front() : '0;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL wrap_fill_w%0d: got adr=%h dat=%h, required adr=%h dat=%h", i, o.adr, o.dat, e.adr, e.dat);
      end
    end
    n_checks++;
    if (wr_ptr !== PW'(BSIZE - 1)) begin n_fail++; $display("[TB] FAIL wrap_preload_ptr: got %0d, required %0d", wr_ptr, BSIZE - 1); end
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_writes(2, "wrap");
    n_checks += 3;
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    if (o !== {BASE + 32'(BSIZE - 4), 4'b1000, 32'h11111111})
      begin n_fail++; $display("[TB] FAIL wrap_last: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    if (o !== {BASE, 4'b0001, 32'h22222222})
      begin n_fail++; $display("[TB] FAIL wrap_first: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
    if (wr_ptr !== PW'(1)) begin n_fail++; $display("[TB] FAIL wrap_ptr: got %0d, required 1", wr_ptr); end
  endtask

  task automatic test_overflow();
    do_reset();
    ack_mode = 0;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    repeat (10) @(negedge clk);
    n_checks += 4;
    if (overflow !== 1'b1)          begin n_fail++; $display("[TB] FAIL ovf_flag: got %b, required 1", overflow); end
    if (obs.size() != 0)            begin n_fail++; $display("[TB] FAIL ovf_early: got %0d writes, required 0", obs.size()); end
    if (wb_cyc !== 1'b1)            begin n_fail++; $display("[TB] FAIL ovf_cyc_held: got %b, required 1", wb_cyc); end
    if (wb_dat !== 32'h01010101)    begin n_fail++; $display("[TB] FAIL ovf_dat_held: got %h, required 01010101", wb_dat); end
    ack_mode = 1;
    wait_writes(4, "ovf");
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      wr_t e, o;
      e    = exp_write(8'(i), mptr);
      mptr = mptr + 1;
      o    = (obs.size() > 0) ? obs.pop_front() : '0;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL ovf_w%0d: got adr=%h sel=%b dat=%h, required dat=%h", i, o.adr, o.sel, o.dat, e.dat);
      end
    end
    n_checks += 2;
    if (obs.size() != 0)   begin n_fail++; $display("[TB] FAIL ovf_extra: got %0d extra writes, required 0", obs.size()); end
    if (wr_ptr !== PW'(4)) begin n_fail++; $display("[TB] FAIL ovf_ptr: got %0d, required 4", wr_ptr); end
  endtask

  task automatic test_frame_err();
    wr_t o;
    do_reset();
    ack_mode = 1;
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    n_checks += 3;
    if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ferr_flag: got %b, required 1", frame_err); end
    if (obs.size() != 0)    begin n_fail++; $display("[TB] FAIL ferr_write: got %0d writes, required 0", obs.size()); end
    if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL ferr_ovf: got %b, required 0", overflow); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ferr_clr: got %b, required 0", frame_err); end
    send_byte(8'h66, 1'b1);
    wait_writes(1, "ferr");
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    n_checks += 2;
    if (o !== exp_write(8'h66, 0)) begin n_fail++; $display("[TB] FAIL ferr_next: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
    if (frame_err !== 1'b0)        begin n_fail++; $display("[TB] FAIL ferr_after: got %b, required 0", frame_err); end
  endtask

  task automatic test_glitch();
    wr_t o;
    do_reset();
    ack_mode = 1;
    @(negedge clk) rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks += 4;
    if (obs.size() != 0)    begin n_fail++; $display("[TB] FAIL glitch_write: got %0d writes, required 0", obs.size()); end
    if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_ferr: got %b, required 0", frame_err); end
    if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL glitch_ovf: got %b, required 0", overflow); end
    if (wb_cyc !== 1'b0)    begin n_fail++; $display("[TB] FAIL glitch_cyc: got %b, required 0", wb_cyc); end
    send_byte(8'h77, 1'b1);
    wait_writes(1, "glitch");
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    n_checks++;
    if (o !== exp_write(8'h77, 0)) begin n_fail++; $display("[TB] FAIL glitch_next: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
  endtask

  task automatic test_reset_mid_write();
    wr_t o;
    int  budget = 400;
    do_reset();
    ack_mode = 0;
    send_byte(8'h99, 1'b1);
    while (!wb_cyc && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (wb_cyc !== 1'b1) begin n_fail++; $display("[TB] FAIL rstw_cyc_rise: got %b, required 1", wb_cyc); end
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (wb_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL rstw_cyc_drop: got %b, required 0", wb_cyc); end
    if (wr_ptr !== '0)   begin n_fail++; $display("[TB] FAIL rstw_ptr: got %0d, required 0", wr_ptr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs.delete();
    ack_mode = 1;
    repeat (20) @(negedge clk);
    n_checks += 3;
    if (wb_cyc !== 1'b0)  begin n_fail++; $display("[TB] FAIL rstw_idle_cyc: got %b, required 0", wb_cyc); end
    if (obs.size() != 0)  begin n_fail++; $display("[TB] FAIL rstw_spurious: got %0d writes, required 0", obs.size()); end
    if (wr_ptr !== '0)    begin n_fail++; $display("[TB] FAIL rstw_ptr_after: got %0d, required 0", wr_ptr); end
    send_byte(8'h42, 1'b1);
    wait_writes(1, "rstw");
    o = (obs.size() > 0) ? obs.pop_front() : '0;
    n_checks += 3;
    if (o !== exp_write(8'h42, 0)) begin n_fail++; $display("[TB] FAIL rstw_next: got adr=%h sel=%b dat=%h", o.adr, o.sel, o.dat); end
    if (obs.size() != 0)           begin n_fail++; $display("[TB] FAIL rstw_extra: got %0d extra writes, required 0", obs.size()); end
    if (wr_ptr !== PW'(1))         begin n_fail++; $display("[TB] FAIL rstw_ptr_final: got %0d, required 1", wr_ptr); end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_random();
    test_wrap();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
